// File: rtl/rib_xbar.sv
// rib_xbar: parametrised RIB crossbar, NUM_M masters onto NUM_S slaves,
// one transaction at a time, with decode-error and timeout responses.
// Ports: clk, rst (sync, active-high);
//   m_req_i/m_we_i/m_addr_i/m_wdata_i  flattened master requests in;
//   m_rdata_o/m_ready_o/m_err_o        per-master response out;
//   s_req_o/s_we_o                     one-hot slave select and write enable;
//   s_addr_o/s_wdata_o                 granted master's address/data broadcast;
//   s_rdata_i/s_ready_i                flattened slave responses in;
//   hold_flag_o                        core stall while a HOLD_MASK master owns the bus.
module rib_xbar #(
    parameter int                NUM_M     = 4,
    parameter int                NUM_S     = 8,
    parameter int                ADDR_W    = 32,
    parameter int                DATA_W    = 32,
    parameter int                SEL_W     = 4,
    parameter int                ARB_MODE  = 0,
    parameter logic [7:0]        HOLD_MASK = 8'b0000_1101,
    parameter int                TIMEOUT   = 255,
    parameter logic [DATA_W-1:0] ERR_DATA  = 32'hDEAD_BEEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_M-1:0]        m_req_i,
    input  logic [NUM_M-1:0]        m_we_i,
    input  logic [NUM_M*ADDR_W-1:0] m_addr_i,
    input  logic [NUM_M*DATA_W-1:0] m_wdata_i,
    output logic [NUM_M*DATA_W-1:0] m_rdata_o,
    output logic [NUM_M-1:0]        m_ready_o,
    output logic [NUM_M-1:0]        m_err_o,
    output logic [NUM_S-1:0]        s_req_o,
    output logic [NUM_S-1:0]        s_we_o,
    output logic [ADDR_W-1:0]       s_addr_o,
    output logic [DATA_W-1:0]       s_wdata_o,
    input  logic [NUM_S*DATA_W-1:0] s_rdata_i,
    input  logic [NUM_S-1:0]        s_ready_i,
    output logic                    hold_flag_o
);

    localparam int MW = $clog2(NUM_M);
    localparam int CW = $clog2(TIMEOUT + 2);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t         state_q, state_d;
    logic [MW-1:0]  gnt_q, gnt_d;
    logic [MW-1:0]  rr_q, rr_d;
    logic [CW-1:0]  cnt_q, cnt_d;

    logic [MW-1:0]     win;
    logic              g_req, g_we, g_hold;
    logic [ADDR_W-1:0] g_addr;
    logic [DATA_W-1:0] g_wdata;
    logic [SEL_W-1:0]  sel;
    logic              sel_ok;
    logic              sel_rdy;
    logic [DATA_W-1:0] sel_rdata;
    logic [NUM_S-1:0]  sel_oh;
    logic              tmo;
    logic              done, err;

    // Arbitration: scan start is 0 (fixed) or rr_q (round robin), wrapping.
    always_comb begin
        logic found;
        int   idx;
        win   = '0;
        found = 1'b0;
        idx   = 0;
        for (int i = 0; i < NUM_M; i++) begin
            idx = (ARB_MODE == 1) ? int'(rr_q) + i : i;
            if (idx >= NUM_M) idx = idx - NUM_M;
            if (!found && m_req_i[idx]) begin
                win   = MW'(idx);
                found = 1'b1;
            end
        end
    end

    // Granted master's request fields.
    always_comb begin
        g_req   = 1'b0;
        g_we    = 1'b0;
        g_hold  = 1'b0;
        g_addr  = '0;
        g_wdata = '0;
        for (int k = 0; k < NUM_M; k++) begin
            if (gnt_q == MW'(k)) begin
                g_req   = m_req_i[k];
                g_we    = m_we_i[k];
                g_hold  = HOLD_MASK[k];
                g_addr  = m_addr_i[k*ADDR_W +: ADDR_W];
                g_wdata = m_wdata_i[k*DATA_W +: DATA_W];
            end
        end
    end

    assign sel    = g_addr[ADDR_W-1 -: SEL_W];
    assign sel_ok = int'(sel) < NUM_S;

    always_comb begin
        sel_oh    = '0;
        sel_rdy   = 1'b0;
        sel_rdata = '0;
        for (int s = 0; s < NUM_S; s++) begin
            if (sel == SEL_W'(s)) begin
                sel_oh[s] = 1'b1;
                sel_rdy   = s_ready_i[s];
                sel_rdata = s_rdata_i[s*DATA_W +: DATA_W];
            end
        end
    end

    // cnt_q counts stalled BUSY cycles already elapsed, so the current
    // cycle is the TIMEOUT-th one when cnt_q == TIMEOUT-1.
    assign tmo = (TIMEOUT != 0) && (int'(cnt_q) == TIMEOUT - 1);

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        rr_d        = rr_q;
        cnt_d       = cnt_q;
        done        = 1'b0;
        err         = 1'b0;
        s_req_o     = '0;
        s_we_o      = '0;
        s_addr_o    = '0;
        s_wdata_o   = '0;
        hold_flag_o = 1'b0;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (|m_req_i) begin
                    gnt_d   = win;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                s_addr_o    = g_addr;
                s_wdata_o   = g_wdata;
                hold_flag_o = g_hold;
                if (!g_req) begin
                    state_d = IDLE;
                end else if (!sel_ok) begin
                    done = 1'b1;
                    err  = 1'b1;
                end else begin
                    s_req_o = sel_oh;
                    s_we_o  = g_we ? sel_oh : '0;
                    if (sel_rdy) begin
                        done = 1'b1;
                    end else if (tmo) begin
                        done = 1'b1;
                        err  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                if (done) begin
                    state_d = IDLE;
                    rr_d    = (int'(gnt_q) == NUM_M - 1) ? '0 : gnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        m_ready_o = '0;
        m_err_o   = '0;
        m_rdata_o = '0;
        for (int k = 0; k < NUM_M; k++) begin
            if (done && gnt_q == MW'(k)) begin
                m_ready_o[k] = 1'b1;
                m_err_o[k]   = err;
                m_rdata_o[k*DATA_W +: DATA_W] = err ? ERR_DATA : sel_rdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            rr_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            rr_q    <= rr_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_rib_xbar.sv
// tb_rib_xbar: random traffic into a fixed-priority and a round-robin
// rib_xbar, every output compared each cycle against a behavioural model.
module tb_rib_xbar;

    localparam int  NM  = 4;
    localparam int  NS  = 8;
    localparam int  TO  = 4;
    localparam int  NCYC = 4000;
    localparam logic [3:0]  HOLD = 4'b1101;
    localparam logic [31:0] ERRD = 32'hDEAD_BEEF;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   m_req, m_we;
    logic [127:0] m_addr, m_wdata;
    logic [255:0] s_rdata;
    logic [7:0]   s_ready;

    logic [127:0] o_rd   [2];
    logic [3:0]   o_rdy  [2];
    logic [3:0]   o_err  [2];
    logic [7:0]   o_sreq [2];
    logic [7:0]   o_swe  [2];
    logic [31:0]  o_sa   [2];
    logic [31:0]  o_sw   [2];
    logic         o_hold [2];

    logic [31:0] a_addr [NM];
    logic [31:0] a_wd   [NM];
    logic        a_req  [NM];
    logic        a_we   [NM];

    // model state per instance: 0 = fixed priority, 1 = round robin
    bit mb [2];
    int mg [2];
    int mr [2];
    int nb [2];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    rib_xbar #(.ARB_MODE(0), .TIMEOUT(TO)) u_fp (
        .clk(clk), .rst(rst),
        .m_req_i(m_req), .m_we_i(m_we),
        .m_addr_i(m_addr), .m_wdata_i(m_wdata),
        .m_rdata_o(o_rd[0]), .m_ready_o(o_rdy[0]), .m_err_o(o_err[0]),
        .s_req_o(o_sreq[0]), .s_we_o(o_swe[0]),
        .s_addr_o(o_sa[0]), .s_wdata_o(o_sw[0]),
        .s_rdata_i(s_rdata), .s_ready_i(s_ready),
        .hold_flag_o(o_hold[0])
    );

    rib_xbar #(.ARB_MODE(1), .TIMEOUT(TO)) u_rr (
        .clk(clk), .rst(rst),
        .m_req_i(m_req), .m_we_i(m_we),
        .m_addr_i(m_addr), .m_wdata_i(m_wdata),
        .m_rdata_o(o_rd[1]), .m_ready_o(o_rdy[1]), .m_err_o(o_err[1]),
        .s_req_o(o_sreq[1]), .s_we_o(o_swe[1]),
        .s_addr_o(o_sa[1]), .s_wdata_o(o_sw[1]),
        .s_rdata_i(s_rdata), .s_ready_i(s_ready),
        .hold_flag_o(o_hold[1])
    );

    task automatic chk(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int pick(input int d);
        int w;
        w = -1;
        for (int i = 0; i < NM; i++) begin
            int idx;
            idx = (d == 1) ? (mr[d] + i) % NM : i;
            if (w < 0 && a_req[idx]) w = idx;
        end
        return w;
    endfunction

    // Compare this cycle's outputs and advance the model across the edge.
    task automatic step(input int d, input bit check);
        logic [3:0]   e_rdy, e_err;
        logic [127:0] e_rd;
        logic [7:0]   e_sreq, e_swe;
        logic [31:0]  e_sa, e_sw, data;
        logic         e_hold;
        bit           done, abort, err;
        int           g, sel;
        e_rdy = '0; e_err = '0; e_rd = '0; e_sreq = '0; e_swe = '0;
        e_sa = '0; e_sw = '0; e_hold = 1'b0; data = '0;
        done = 0; abort = 0; err = 0; g = mg[d]; sel = 0;
        if (mb[d]) begin
            sel    = int'(a_addr[g][31:28]);
            e_sa   = a_addr[g];
            e_sw   = a_wd[g];
            e_hold = HOLD[g];
            if (!a_req[g]) begin
                abort = 1;
            end else if (sel >= NS) begin
                done = 1; err = 1;
            end else begin
                e_sreq = 8'(1 << sel);
                e_swe  = a_we[g] ? e_sreq : 8'h00;
                if (s_ready[sel]) begin
                    done = 1;
                    data = s_rdata[sel*32 +: 32];
                end else if (nb[d] == TO) begin
                    done = 1; err = 1;
                end
            end
            if (err) data = ERRD;
            if (done) begin
                e_rdy = 4'(1 << g);
                e_err = err ? e_rdy : 4'h0;
                e_rd[g*32 +: 32] = data;
            end
        end
        if (check) begin
            chk($sformatf("u%0d.m_ready", d), 128'(o_rdy[d]), 128'(e_rdy));
            chk($sformatf("u%0d.m_err", d), 128'(o_err[d]), 128'(e_err));
            chk($sformatf("u%0d.m_rdata", d), o_rd[d], e_rd);
            chk($sformatf("u%0d.s_req", d), 128'(o_sreq[d]), 128'(e_sreq));
            chk($sformatf("u%0d.s_we", d), 128'(o_swe[d]), 128'(e_swe));
            chk($sformatf("u%0d.s_addr", d), 128'(o_sa[d]), 128'(e_sa));
            chk($sformatf("u%0d.s_wdata", d), 128'(o_sw[d]), 128'(e_sw));
            chk($sformatf("u%0d.hold", d), 128'(o_hold[d]), 128'(e_hold));
        end
        if (rst) begin
            mb[d] = 0; mg[d] = 0; mr[d] = 0; nb[d] = 0;
        end else if (!mb[d]) begin
            g = pick(d);
            if (g >= 0) begin
                mb[d] = 1; mg[d] = g; nb[d] = 1;
            end
        end else if (done || abort) begin
            mb[d] = 0;
            if (done) mr[d] = (mg[d] + 1) % NM;
        end else begin
            nb[d]++;
        end
    endtask

    initial begin
        rst = 1'b1;
        m_req = '0; m_we = '0; m_addr = '0; m_wdata = '0;
        s_rdata = '0; s_ready = '0;
        for (int k = 0; k < NM; k++) begin
            a_addr[k] = '0; a_wd[k] = '0; a_req[k] = 0; a_we[k] = 0;
        end
        for (int d = 0; d < 2; d++) begin
            mb[d] = 0; mg[d] = 0; mr[d] = 0; nb[d] = 0;
        end
        for (int cyc = 0; cyc < NCYC; cyc++) begin
            int rdy_div;
            @(negedge clk);
            rst = (cyc < 2) || ($urandom_range(0, 99) == 0);
            for (int k = 0; k < NM; k++) begin
                if ($urandom_range(0, 5) == 0) begin
                    a_req[k] = !a_req[k];
                    if (a_req[k]) begin
                        a_addr[k] = {4'($urandom_range(0, 9)),
                                     28'($urandom)};
                        a_wd[k]   = $urandom;
                        a_we[k]   = 1'($urandom_range(0, 1));
                    end
                end
                m_req[k] = a_req[k];
                m_we[k]  = a_we[k];
                m_addr[k*32 +: 32]  = a_addr[k];
                m_wdata[k*32 +: 32] = a_wd[k];
            end
            // phases: balanced, mostly stalled (timeouts), mostly ready
            rdy_div = (cyc < 1500) ? 2 : (cyc < 3000) ? 6 : 8;
            for (int s = 0; s < NS; s++) begin
                if (rdy_div == 8)
                    s_ready[s] = ($urandom_range(0, 7) != 0);
                else
                    s_ready[s] = ($urandom_range(0, rdy_div - 1) == 0);
                s_rdata[s*32 +: 32] = $urandom;
            end
            #1;
            for (int d = 0; d < 2; d++) step(d, cyc >= 1);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/rib_xbar.md
Name: rib_xbar

Overview:
- Parametrised successor to the fixed 4-master/8-slave RIB interconnect.
- Configurable master and slave counts, with selectable fixed-priority or round-robin arbitration.
- Registered grant with transaction lock; core hold flag driven from a per-master mask.
- Decode-error and timeout responses, so a master never hangs on an absent or stalled slave.
- Sits between the cores/JTAG/uart_debug masters and the ROM/RAM/peripheral slaves in the SoC top.

Parameters:
- NUM_M, 4: number of masters (2..8).
- NUM_S, 8: number of slaves (1..16).
- ADDR_W, 32: address width.
- DATA_W, 32: data width.
- SEL_W, 4: slave index width; the index is taken from addr[ADDR_W-1 -: SEL_W].
- ARB_MODE, 0: 0 = fixed priority (lowest master index wins); 1 = round robin.
- HOLD_MASK, 4'b1101: masters whose grant asserts hold_flag_o.
- TIMEOUT, 255: maximum BUSY cycles without s_ready_i before an error response; 0 disables the timeout.
- ERR_DATA, 32'hDEAD_BEEF: read data returned on an error response.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- m_req_i  in  NUM_M  request, one bit per master.
- m_we_i  in  NUM_M  write enable, one bit per master.
- m_addr_i  in  NUM_M*ADDR_W  flattened master addresses; master k occupies [k*ADDR_W +: ADDR_W].
- m_wdata_i  in  NUM_M*DATA_W  flattened master write data.
- m_rdata_o  out  NUM_M*DATA_W  read data, valid to a master while its m_ready_o is high.
- m_ready_o  out  NUM_M  transaction complete, one-cycle pulse.
- m_err_o  out  NUM_M  error qualifier, high together with m_ready_o.
- s_req_o  out  NUM_S  one-hot slave select.
- s_we_o  out  NUM_S  write enable; equals s_req_o AND the granted master's we.
- s_addr_o  out  ADDR_W  granted master address, broadcast to all slaves.
- s_wdata_o  out  DATA_W  granted master write data, broadcast to all slaves.
- s_rdata_i  in  NUM_S*DATA_W  flattened slave read data.
- s_ready_i  in  NUM_S  per-slave completion.
- hold_flag_o  out  1  pipeline hold to the cores.

Behaviour:
- Reset (rst=1 at a clk edge):
  - state=IDLE, gnt=0, rr_ptr=0, timeout counter=0.
  - All outputs 0; s_addr_o and s_wdata_o are 0.
  - Reset mid-transaction abandons the transfer; no m_ready_o is issued.
- States: IDLE, BUSY.
- IDLE:
  - All s_req_o, m_ready_o and hold_flag_o are 0.
  - If m_req_i != 0, register gnt = arbitration winner and go to BUSY next cycle; otherwise stay in IDLE.
- Arbitration:
  - ARB_MODE=0: lowest set index of m_req_i wins.
  - ARB_MODE=1: first set index scanning from rr_ptr upward, wrapping from NUM_M-1 to 0.
  - rr_ptr becomes (gnt+1) mod NUM_M when a transaction completes, including error completions; it is unchanged on abort.
- BUSY routing (g = gnt, sel = slave index decoded from m_addr_i[g]):
  - s_addr_o/s_wdata_o = master g's address/write data.
  - s_req_o[sel]=1 only if m_req_i[g]=1 and sel<NUM_S.
  - hold_flag_o = HOLD_MASK[g].
- Normal completion: in a BUSY cycle with s_ready_i[sel]=1:
  - m_ready_o[g]=1 combinationally in that same cycle, m_rdata_o[g]=s_rdata_i[sel], m_err_o[g]=0.
  - Return to IDLE next cycle.
  - Minimum latency: 2 cycles from req to ready (1 grant cycle + 1 access cycle). Back-to-back transfers incur one IDLE bubble.
- Decode error: sel>=NUM_S gives, on the first BUSY cycle, m_ready_o[g]=1, m_err_o[g]=1, m_rdata_o[g]=ERR_DATA, no s_req_o asserted; return to IDLE.
- Timeout:
  - The counter increments every BUSY cycle without s_ready_i[sel] and clears in IDLE.
  - When the counter reaches TIMEOUT, that cycle issues m_ready_o[g]=1, m_err_o[g]=1, m_rdata_o[g]=ERR_DATA; s_req_o stays 1 in that cycle; return to IDLE.
  - A slave ready arriving in the same cycle as the timeout takes priority: normal completion.
- Abort: if m_req_i[g] falls while BUSY, return to IDLE next cycle with no m_ready_o.
- Non-granted masters always see m_ready_o=0, m_err_o=0, m_rdata_o=0.
- Grant is locked for the whole transaction. Requests from other masters during BUSY are ignored until the next IDLE.

Test Plan:
- ARB_MODE=0, m1 and m3 request the same cycle, m1 reads addr 0x1000_0004 with slave1 ready=1, rdata=0x1234_5678 -> s_req_o=0x02 on cycle 1; m_ready_o[1]=1 with rdata 0x1234_5678 on cycle 1; m3 is served from cycle 3.
- ARB_MODE=1, masters 0..3 requesting continuously, all slaves ready=1 -> grant order 0,1,2,3,0; each transaction takes 2 cycles.
- NUM_S=8, m0 addr 0x9000_0000 -> on cycle 1 m_ready_o[0]=1, m_err_o[0]=1, rdata=0xDEADBEEF; s_req_o stays 0.
- TIMEOUT=4, slave2 ready held 0 -> error response on the 4th BUSY cycle with rdata 0xDEADBEEF; with ready=1 on that same cycle -> normal completion, m_err_o=0.
- m2 (HOLD_MASK bit 2 = 1) writes 0xA5A5_A5A5 to slave1 -> hold_flag_o=1 and s_we_o=0x02 during BUSY; with m1 granted (bit 1 = 0) -> hold_flag_o=0.
- rst=1 while BUSY with slave stalled -> next cycle all outputs 0 and state IDLE; a new request after reset is granted normally, and under ARB_MODE=1 arbitration restarts from master 0.
